// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider with shadowed divisors applied at period wrap.
// Optional DIVIDER_DUTY_EN macro adds a per-channel programmable high time (DUTY_IN).
module prog_clock_divider #(
    parameter int N_CH        = 4,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 50_000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [N_CH-1:0]         EN,
    input  logic [N_CH-1:0]         LOAD,
    input  logic [N_CH*WIDTH-1:0]   DIV_IN,
`ifdef DIVIDER_DUTY_EN
    input  logic [N_CH*WIDTH-1:0]   DUTY_IN,
`endif
    output logic [N_CH-1:0]         CLK_OUT,
    output logic [N_CH-1:0]         TICK,
    output logic [N_CH-1:0]         PENDING
);

    localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);
`ifdef DIVIDER_DUTY_EN
    localparam logic [WIDTH-1:0] DEF_DUTY = WIDTH'(DEFAULT_DIV / 2);
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [WIDTH-1:0] cnt, d, s;
        logic [WIDTH-1:0] cnt_n, d_n, s_n, h_n, din;
        logic             p, p_n, wrap, clk_q, tick_q, clk_n;
`ifdef DIVIDER_DUTY_EN
        logic [WIDTH-1:0] a, ds, a_n, ds_n, dmax, duty;
        assign duty = DUTY_IN[i*WIDTH +: WIDTH];
`endif

        assign din = DIV_IN[i*WIDTH +: WIDTH];

        always_comb begin
            cnt_n = cnt;
            d_n   = d;
            s_n   = s;
            p_n   = p;
            wrap  = EN[i] && (cnt == d - ONE);
`ifdef DIVIDER_DUTY_EN
            a_n   = a;
            ds_n  = ds;
`endif
            if (!EN[i]) begin
                cnt_n = d - ONE;
            end else if (wrap) begin
                cnt_n = '0;
                d_n   = s;
                p_n   = 1'b0;
`ifdef DIVIDER_DUTY_EN
                a_n   = ds;
`endif
            end else begin
                cnt_n = cnt + ONE;
            end
            // A load on the wrap edge still leaves a fresh value pending
            if (LOAD[i]) begin
                s_n = (din < TWO) ? TWO : din;
                p_n = 1'b1;
`ifdef DIVIDER_DUTY_EN
                ds_n = duty;
`endif
            end
`ifdef DIVIDER_DUTY_EN
            dmax = d_n - ONE;
            if (a_n < ONE)       h_n = ONE;
            else if (a_n > dmax) h_n = dmax;
            else                 h_n = a_n;
`else
            h_n = d_n - (d_n >> 1);
`endif
            clk_n = EN[i] && (cnt_n < h_n);
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                cnt    <= DEF - ONE;
                d      <= DEF;
                s      <= DEF;
                p      <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
`ifdef DIVIDER_DUTY_EN
                a      <= DEF_DUTY;
                ds     <= DEF_DUTY;
`endif
            end else begin
                cnt    <= cnt_n;
                d      <= d_n;
                s      <= s_n;
                p      <= p_n;
                clk_q  <= clk_n;
                tick_q <= wrap;
`ifdef DIVIDER_DUTY_EN
                a      <= a_n;
                ds     <= ds_n;
`endif
            end
        end

        assign CLK_OUT[i] = clk_q;
        assign TICK[i]    = tick_q;
        assign PENDING[i] = p;
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Randomized bench for prog_clock_divider against a period-level reference model.
module tb_prog_clock_divider;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int DD = 50_000;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   en, load;
    logic [N*W-1:0] div_in;
    logic [N-1:0]   clk_out, tick, pending;

    int checks = 0;
    int failures = 0;

    // model: position inside current period, active/shadow divisor, pending
    int     m_d[N], m_s[N], m_pos[N];
    bit     m_run[N], m_pend[N], m_clk[N], m_tick[N];

    prog_clock_divider #(.N_CH(N), .WIDTH(W), .DEFAULT_DIV(DD)) dut (
        .CLK(clk), .RST(rst), .EN(en), .LOAD(load), .DIV_IN(div_in),
        .CLK_OUT(clk_out), .TICK(tick), .PENDING(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_d[i] = DD; m_s[i] = DD; m_pos[i] = 0;
            m_run[i] = 0; m_pend[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            int v;
            v = int'(div_in[i*W +: W]);
            if (v < 2) v = 2;
            m_tick[i] = 0;
            if (en[i]) begin
                if (!m_run[i] || m_pos[i] == m_d[i] - 1) begin
                    m_d[i] = m_s[i];
                    m_pos[i] = 0;
                    m_pend[i] = 0;
                    m_tick[i] = 1;
                end else begin
                    m_pos[i]++;
                end
                m_run[i] = 1;
                m_clk[i] = (m_pos[i] < (m_d[i] + 1) / 2);
            end else begin
                m_run[i] = 0;
                m_clk[i] = 0;
            end
            if (load[i]) begin
                m_s[i] = v;
                m_pend[i] = 1;
            end
        end
    endtask

    task automatic compare();
        logic [N-1:0] ec, et, ep;
        for (int i = 0; i < N; i++) begin
            ec[i] = m_clk[i]; et[i] = m_tick[i]; ep[i] = m_pend[i];
        end
        chk("clk_out", 32'(clk_out), 32'(ec));
        chk("tick", 32'(tick), 32'(et));
        chk("pending", 32'(pending), 32'(ep));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic rand_inputs(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                if ($urandom_range(0, 39) == 0) en[i] = ~en[i];
                load[i] = ($urandom_range(0, 19) == 0);
                div_in[i*W +: W] = W'($urandom_range(0, 12));
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = '0; load = '0; div_in = '0;
        model_reset();
        #2;
        chk("rst_clk_out", 32'(clk_out), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // channel 0 runs the default divisor for a full period plus its restart
        en[0] = 1'b1;
        for (int c = 0; c < DD + 3; c++) begin
            cyc();
            rand_inputs(4'b1110);
        end

        // fully random traffic on every channel
        for (int c = 0; c < 4000; c++) begin
            cyc();
            rand_inputs(4'b1111);
        end

        // D=10 on ch0, load 4 at cnt=3, reset at cnt=7 with pending set
        en = '0; load = '0;
        cyc();
        load[0] = 1'b1; div_in[0 +: W] = W'(10);
        cyc();
        load[0] = 1'b0; en[0] = 1'b1;
        repeat (4) cyc();
        load[0] = 1'b1; div_in[0 +: W] = W'(4);
        cyc();
        load[0] = 1'b0;
        repeat (3) cyc();
        chk("pre_rst_pending0", 32'(pending[0]), 32'h1);
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_clk_out", 32'(clk_out), 32'h0);
        chk("async_rst_tick", 32'(tick), 32'h0);
        chk("async_rst_pending", 32'(pending), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        // default divisor restored: output stays high well past 10 cycles
        repeat (30) cyc();
        chk("restart_high", 32'(clk_out[0]), 32'h1);

        // clamp of 0 and 1 on ch3 gives a 2-cycle period
        en = '0; load = 4'b1000; div_in[3*W +: W] = W'(0);
        cyc();
        load = '0; en[3] = 1'b1;
        repeat (6) cyc();
        load[3] = 1'b1; div_in[3*W +: W] = W'(1);
        cyc();
        load = '0;
        repeat (8) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
